// File: rtl/pe_nip_pkg.sv
// pe_nip_pkg: shared types and width helpers for the pe_nip_dot inner-product engine.
`default_nettype none

package pe_nip_pkg;

  typedef enum logic {
    MODE_SVP = 1'b0,
    MODE_DOT = 1'b1
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_e;

  // Number of adder-tree stages.
  function automatic int tree_k(input int n);
    return $clog2(n);
  endfunction

  // Full-precision width of the tree sum.
  function automatic int tree_w(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction

  // Accumulator width when saturation is enabled.
  function automatic int acc_w(input int dw, input int n, input int cw);
    return 2 * dw + $clog2(n) + cw;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pe_nip_addtree.sv
// pe_nip_addtree: registered pairwise reduction of N signed operands with stall enable and sideband.
`default_nettype none

module pe_nip_addtree
  import pe_nip_pkg::*;
#(
  parameter int N    = 8,
  parameter int IN_W = 64,
  parameter int SB_W = 1
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                en,
  input  logic                                in_valid,
  input  logic [N*IN_W-1:0]                   in_data,
  input  logic [SB_W-1:0]                     in_sb,
  output logic                                out_valid,
  output logic signed [IN_W+tree_k(N)-1:0]    out_sum,
  output logic [SB_W-1:0]                     out_sb
);

  localparam int K  = tree_k(N);
  localparam int OW = IN_W + K;

  // Heap-ordered tree: node 0 is the root, leaves sit at N-1..2N-2.
  logic signed [OW-1:0] node  [2*N-1];
  logic signed [OW-1:0] inner [N-1];
  logic [K-1:0]         v_pipe;
  logic [SB_W-1:0]      sb_pipe [K];

  always_comb begin
    for (int i = 0; i < N - 1; i++) begin
      node[i] = inner[i];
    end
    for (int j = 0; j < N; j++) begin
      node[N-1+j] = OW'($signed(in_data[j*IN_W +: IN_W]));
    end
  end

  always_ff @(posedge clock) begin
    if (en) begin
      for (int i = 0; i < N - 1; i++) begin
        inner[i] <= node[2*i+1] + node[2*i+2];
      end
      sb_pipe[0] <= in_sb;
      for (int s = 1; s < K; s++) begin
        sb_pipe[s] <= sb_pipe[s-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      v_pipe <= '0;
    end else if (en) begin
      v_pipe[0] <= in_valid;
      for (int s = 1; s < K; s++) begin
        v_pipe[s] <= v_pipe[s-1];
      end
    end
  end

  assign out_valid = v_pipe[K-1];
  assign out_sb    = sb_pipe[K-1];
  assign out_sum   = inner[0];

endmodule

`default_nettype wire

// File: rtl/pe_nip_dot.sv
// pe_nip_dot: N-lane streaming inner-product engine (SVP lane products or accumulated DOT frames).
// Optional macro PE_NIP_SAT_EN: wide accumulator with saturated outputs and io_out_sat flag.
`default_nettype none

module pe_nip_dot
  import pe_nip_pkg::*;
#(
  parameter int N      = 8,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_in_valid,
  output logic                  io_in_ready,
  input  logic [N*DATA_W-1:0]   io_in_x,
  input  logic [N*DATA_W-1:0]   io_in_y,
  input  logic                  io_in_mode,
  input  logic                  io_in_sub,
  input  logic                  io_in_last,
  output logic                  io_out_valid,
  input  logic                  io_out_ready,
  output logic [N*DATA_W-1:0]   io_out_vec,
  output logic [DATA_W-1:0]     io_out_sum,
  output logic [CNT_W-1:0]      io_out_count,
  output logic                  io_out_sat
);

  localparam int PW   = 2 * DATA_W;
  localparam int TW   = tree_w(DATA_W, N);
  localparam int SB_W = 4 + N * DATA_W;
`ifdef PE_NIP_SAT_EN
  localparam int AW = acc_w(DATA_W, N, CNT_W);
  localparam logic [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};
`else
  localparam int AW = DATA_W;
`endif

  logic en;
  assign en          = !io_out_valid || io_out_ready;
  assign io_in_ready = en;

  // Stage M: lane products
  logic              m_valid, m_mode, m_sub, m_last;
  logic [N*PW-1:0]   m_prod;

  always_ff @(posedge clock) begin
    if (reset) begin
      m_valid <= 1'b0;
    end else if (en) begin
      m_valid <= io_in_valid;
    end
  end

  always_ff @(posedge clock) begin
    if (en) begin
      m_mode <= io_in_mode;
      m_sub  <= io_in_sub;
      m_last <= io_in_last;
      for (int i = 0; i < N; i++) begin
        m_prod[i*PW +: PW] <= PW'($signed(io_in_x[i*DATA_W +: DATA_W]))
                            * PW'($signed(io_in_y[i*DATA_W +: DATA_W]));
      end
    end
  end

  // SVP lane results are narrowed here so only DATA_W bits per lane ride the sideband.
  logic [N*DATA_W-1:0] lane_val;
  logic                lane_sat;

  always_comb begin
    lane_val = '0;
    lane_sat = 1'b0;
    for (int i = 0; i < N; i++) begin
`ifdef PE_NIP_SAT_EN
      if (&m_prod[i*PW+DATA_W-1 +: PW-DATA_W+1] || ~|m_prod[i*PW+DATA_W-1 +: PW-DATA_W+1]) begin
        lane_val[i*DATA_W +: DATA_W] = m_prod[i*PW +: DATA_W];
      end else begin
        lane_val[i*DATA_W +: DATA_W] = m_prod[i*PW+PW-1] ? SMIN : SMAX;
        lane_sat = 1'b1;
      end
`else
      lane_val[i*DATA_W +: DATA_W] = m_prod[i*PW +: DATA_W];
`endif
    end
  end

  // Stages T1..Tk
  logic                 t_valid;
  logic signed [TW-1:0] t_sum;
  logic [SB_W-1:0]      t_sb;

  pe_nip_addtree #(
    .N    (N),
    .IN_W (PW),
    .SB_W (SB_W)
  ) u_addtree (
    .clock     (clock),
    .reset     (reset),
    .en        (en),
    .in_valid  (m_valid),
    .in_data   (m_prod),
    .in_sb     ({m_mode, m_sub, m_last, lane_sat, lane_val}),
    .out_valid (t_valid),
    .out_sum   (t_sum),
    .out_sb    (t_sb)
  );

  logic                t_mode, t_sub, t_last, t_lsat;
  logic [N*DATA_W-1:0] t_lane;
  assign t_mode = t_sb[SB_W-1];
  assign t_sub  = t_sb[SB_W-2];
  assign t_last = t_sb[SB_W-3];
  assign t_lsat = t_sb[SB_W-4];
  assign t_lane = t_sb[N*DATA_W-1:0];

  // Stage A: accumulator FSM
  state_e               state;
  logic signed [AW-1:0] acc, acc_base, sum_ext, acc_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [DATA_W-1:0]    dot_sum;
  logic                 dot_sat;

  always_comb begin
    sum_ext  = AW'(t_sum);
    acc_base = (state == ST_IDLE) ? '0 : acc;
    acc_nxt  = t_sub ? (acc_base - sum_ext) : (acc_base + sum_ext);
    cnt_nxt  = (state == ST_IDLE) ? CNT_W'(1) : ((&cnt) ? cnt : cnt + CNT_W'(1));
`ifdef PE_NIP_SAT_EN
    if (&acc_nxt[AW-1:DATA_W-1] || ~|acc_nxt[AW-1:DATA_W-1]) begin
      dot_sum = acc_nxt[DATA_W-1:0];
      dot_sat = 1'b0;
    end else begin
      dot_sum = acc_nxt[AW-1] ? SMIN : SMAX;
      dot_sat = 1'b1;
    end
`else
    dot_sum = acc_nxt;
    dot_sat = 1'b0;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      acc          <= '0;
      cnt          <= '0;
      io_out_valid <= 1'b0;
      io_out_vec   <= '0;
      io_out_sum   <= '0;
      io_out_count <= '0;
      io_out_sat   <= 1'b0;
    end else if (en) begin
      io_out_valid <= 1'b0;
      if (t_valid) begin
        if (t_mode == MODE_DOT) begin
          if (t_last) begin
            io_out_valid <= 1'b1;
            io_out_vec   <= '0;
            io_out_sum   <= dot_sum;
            io_out_count <= cnt_nxt;
            io_out_sat   <= dot_sat;
            state        <= ST_IDLE;
            acc          <= '0;
            cnt          <= '0;
          end else begin
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            state <= ST_ACC;
          end
        end else begin
          // SVP passes through; any partial DOT accumulation stays put.
          io_out_valid <= 1'b1;
          io_out_vec   <= t_lane;
          io_out_sum   <= '0;
          io_out_count <= CNT_W'(1);
          io_out_sat   <= t_lsat;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pe_nip_dot.sv
// tb_pe_nip_dot: directed self-checking bench for pe_nip_dot (N=8, DATA_W=32).
`default_nettype none

module tb_pe_nip_dot;

  localparam int N  = 8;
  localparam int DW = 32;
  localparam int CW = 16;

  logic            clock = 1'b0;
  logic            reset;
  logic            io_in_valid, io_in_ready, io_in_mode, io_in_sub, io_in_last;
  logic [N*DW-1:0] io_in_x, io_in_y;
  logic            io_out_valid, io_out_ready, io_out_sat;
  logic [N*DW-1:0] io_out_vec;
  logic [DW-1:0]   io_out_sum;
  logic [CW-1:0]   io_out_count;

  int checks = 0;
  int errors = 0;

  pe_nip_dot #(.N(N), .DATA_W(DW), .CNT_W(CW)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_in_x      (io_in_x),
    .io_in_y      (io_in_y),
    .io_in_mode   (io_in_mode),
    .io_in_sub    (io_in_sub),
    .io_in_last   (io_in_last),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_out_vec   (io_out_vec),
    .io_out_sum   (io_out_sum),
    .io_out_count (io_out_count),
    .io_out_sat   (io_out_sat)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [N*DW-1:0] obs, input logic [N*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [N*DW-1:0] fill(input int v);
    logic [N*DW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  task automatic drive(input logic mode, input logic sub, input logic last,
                       input logic [N*DW-1:0] x, input logic [N*DW-1:0] y);
    io_in_valid = 1'b1;
    io_in_mode  = mode;
    io_in_sub   = sub;
    io_in_last  = last;
    io_in_x     = x;
    io_in_y     = y;
  endtask

  function automatic logic [N*DW-1:0] bp_x(input int j);
    logic [N*DW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = j * 16 + i + 1;
    return r;
  endfunction

  function automatic logic [N*DW-1:0] bp_exp(input int j);
    logic [N*DW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = -2 * (j * 16 + i + 1);
    return r;
  endfunction

  logic [N*DW-1:0] vx, vexp_a, vexp_b, vy_b;
  int  j, r;
  logic acc_in, xfer, saw_valid;

  initial begin
    reset = 1'b1; io_out_ready = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    io_in_valid = 1'b0;
    repeat (3) tick;
    reset = 1'b0;

    // Reset state
    check("rst_valid", N*DW'(io_out_valid), '0);
    check("rst_sum",   N*DW'(io_out_sum),   '0);
    check("rst_count", N*DW'(io_out_count), '0);
    check("rst_vec",   io_out_vec,           '0);
    check("rst_ready", N*DW'(io_in_ready),  N*DW'(1));

    // DOT two-beat frame: 8*253 + 8*605 = 6864
    drive(1'b1, 1'b0, 1'b0, fill(23), fill(11));
    tick;
    drive(1'b1, 1'b0, 1'b1, fill(-55), fill(-11));
    tick;
    io_in_valid = 1'b0;
    repeat (3) tick;
    check("dot_early", N*DW'(io_out_valid), '0);
    tick;
    check("dot_valid", N*DW'(io_out_valid), N*DW'(1));
    check("dot_sum",   N*DW'(io_out_sum),   N*DW'(32'd6864));
    check("dot_count", N*DW'(io_out_count), N*DW'(16'd2));
    check("dot_vec",   io_out_vec,           '0);
    tick;
    check("dot_drop",  N*DW'(io_out_valid), '0);

    // SVP: two back-to-back beats
    for (int i = 0; i < N; i++) begin
      vx[i*DW +: DW]     = i + 1;
      vexp_a[i*DW +: DW] = -3 * (i + 1);
      vexp_b[i*DW +: DW] = 5 * (i + 1);
    end
    vy_b = fill(5);
    drive(1'b0, 1'b1, 1'b1, vx, fill(-3));
    tick;
    drive(1'b0, 1'b0, 1'b0, vx, vy_b);
    tick;
    io_in_valid = 1'b0;
    repeat (3) tick;
    check("svp_a_valid", N*DW'(io_out_valid), N*DW'(1));
    check("svp_a_vec",   io_out_vec,           vexp_a);
    check("svp_a_count", N*DW'(io_out_count), N*DW'(16'd1));
    check("svp_a_sum",   N*DW'(io_out_sum),   '0);
    tick;
    check("svp_b_vec",   io_out_vec,           vexp_b);
    tick;
    check("svp_drop",    N*DW'(io_out_valid), '0);

    // Subtract: 2024 - 4840
    drive(1'b1, 1'b0, 1'b0, fill(23), fill(11));
    tick;
    drive(1'b1, 1'b1, 1'b1, fill(55), fill(11));
    tick;
    io_in_valid = 1'b0;
    repeat (4) tick;
    check("sub_valid", N*DW'(io_out_valid), N*DW'(1));
    check("sub_sum",   N*DW'(io_out_sum),   N*DW'(32'hFFFF_F500));
    check("sub_count", N*DW'(io_out_count), N*DW'(16'd2));
    repeat (3) tick;

    // Backpressure: ready low for the first 10 cycles while 6 SVP beats stream
    j = 0; r = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      io_out_ready = (cyc >= 10);
      if (j < 6) drive(1'b0, 1'b0, 1'b0, bp_x(j), fill(-2));
      else io_in_valid = 1'b0;
      #1;
      if (cyc == 9) begin
        check("bp_hold_valid", N*DW'(io_out_valid), N*DW'(1));
        check("bp_hold_ready", N*DW'(io_in_ready),  '0);
        check("bp_hold_vec",   io_out_vec,           bp_exp(0));
      end
      acc_in = io_in_valid && io_in_ready;
      xfer   = io_out_valid && io_out_ready;
      if (xfer) begin
        check($sformatf("bp_res%0d", r), io_out_vec, bp_exp(r));
        r++;
      end
      tick;
      if (acc_in) j++;
    end
    check("bp_result_count", N*DW'(r), N*DW'(6));
    io_out_ready = 1'b1;

    // Reset mid-frame: the partial frame must vanish
    repeat (3) begin
      drive(1'b1, 1'b0, 1'b0, fill(23), fill(11));
      tick;
    end
    io_in_valid = 1'b0;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    saw_valid = 1'b0;
    repeat (6) begin
      saw_valid = saw_valid | io_out_valid;
      tick;
    end
    check("rmf_no_output", N*DW'(saw_valid), '0);
    drive(1'b1, 1'b0, 1'b1, fill(23), fill(11));
    tick;
    io_in_valid = 1'b0;
    repeat (4) tick;
    check("rmf_valid", N*DW'(io_out_valid), N*DW'(1));
    check("rmf_sum",   N*DW'(io_out_sum),   N*DW'(32'd2024));
    check("rmf_count", N*DW'(io_out_count), N*DW'(16'd1));
    tick;

    // Overflow: 8 * (2^31-1)^2
    drive(1'b1, 1'b0, 1'b1, fill(32'h7FFF_FFFF), fill(32'h7FFF_FFFF));
    tick;
    io_in_valid = 1'b0;
    repeat (4) tick;
    check("ovf_valid", N*DW'(io_out_valid), N*DW'(1));
`ifdef PE_NIP_SAT_EN
    check("ovf_sum", N*DW'(io_out_sum), N*DW'(32'h7FFF_FFFF));
    check("ovf_sat", N*DW'(io_out_sat), N*DW'(1));
`else
    check("ovf_sum", N*DW'(io_out_sum), N*DW'(32'h0000_0008));
    check("ovf_sat", N*DW'(io_out_sat), '0);
`endif
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
